stream_fifo_buffer: RTL and testbench
=====================================

# stream_fifo_buffer

Parametrised valid/ready stream FIFO with first-word-fall-through output, an enable gate, a synchronous flush, occupancy count and an almost-full flag. It sits between two stream stages that follow the team's upstream/downstream handshake. It decouples producer and consumer by up to DEPTH words, and it generalises the single-register stage into a configurable-depth buffer.

## Interface
Parameters:
- WIDTH, 16, data word width in bits (≥1).
- DEPTH, 8, storage depth in words; power of two, ≥2.
- ALMOST_FULL, 6, occupancy at or above which o_almost_full asserts; 1..DEPTH.

Ports:
- i_clock  in  1  single clock; all logic rising-edge.
- i_reset_n  in  1  synchronous, active-low reset.
- i_in_data  in  WIDTH  upstream data.
- i_in_valid  in  1  upstream valid.
- o_in_ready  out  1  upstream ready.
- o_out_data  out  WIDTH  downstream data.
- o_out_valid  out  1  downstream valid.
- i_out_ready  in  1  downstream ready.
- i_enable  in  1  when low, both handshakes stall; contents held.
- i_flush  in  1  synchronous clear of contents.
- o_count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- o_almost_full  out  1  o_count ≥ ALMOST_FULL.

## Operation
- Storage: circular buffer of DEPTH words with write and read pointers of $clog2(DEPTH) bits, which wrap naturally. Occupancy is a separate registered counter.
- Push occurs when i_in_valid && o_in_ready. The word is written at the write pointer, and the write pointer increments.
- Pop occurs when o_out_valid && i_out_ready. The read pointer increments.
- o_in_ready = i_enable && (count < DEPTH). It is combinational from registered state only and never depends on i_out_ready. As a result, a full FIFO does not accept a word in the same cycle as a pop.
- o_out_valid = i_enable && (count != 0).
- o_out_data = storage[read pointer]. It is stable while o_out_valid && !i_out_ready.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged, and both pointers advance.
- The count never exceeds DEPTH and never goes below 0 (guaranteed by the ready/valid gating; assertions are required in the bench).
- Flush: when i_flush=1 at a rising edge, both pointers and the count clear to 0. Any push or pop in that cycle is discarded; flush wins over both. Storage contents are not cleared.
- i_enable=0: o_in_ready=0 and o_out_valid=0, so no push or pop occurs. Pointers, count and contents are held. Flush still takes effect while disabled.
- Reset (i_reset_n=0 at an edge): pointers=0, count=0. Reset overrides flush and enable. Storage is not reset.
- Reset values:
  - o_in_ready = i_enable (FIFO empty).
  - o_out_valid=0, o_count=0.
  - o_almost_full=0.
  - o_out_data is don't-care while o_out_valid=0.

## Timing
- Latency: a word pushed at edge N is presented on o_out_data with o_out_valid=1 after edge N (visible in cycle N+1). There is no same-cycle bypass when empty.
- Throughput: 1 word/cycle sustained when 0 < count < DEPTH and both sides are active.
- Full boundary: at count=DEPTH, o_in_ready=0 even if a pop occurs in that cycle. Ready returns in the cycle after the pop.
- Empty boundary: at count=0, o_out_valid=0 even if a push occurs in that cycle.
- Wrap-around: pointers wrap from DEPTH−1 to 0 with no bubble.
- o_count and o_almost_full update at the same edge as the push or pop that changes occupancy.
- Reset or flush mid-stream: the next cycle shows count=0, o_out_valid=0, o_in_ready=i_enable. Words accepted before the clear are lost and must not reappear.

## Test plan
- Reset with i_enable=1, then push 0x0001..0x0003 on consecutive cycles while i_out_ready=0. Required response:
  - o_count = 1, 2, 3 after successive edges.
  - o_out_data=0x0001 with o_out_valid=1 from the cycle after the first push.
- Fill to DEPTH=8 with i_out_ready=0:
  - o_almost_full rises at count 6.
  - o_in_ready falls at count 8.
  - A 9th valid word is not accepted.
  - Then one pop: ready reasserts the following cycle and count=7.
- Wrap-around: with i_in_valid=1 and i_out_ready=1 continuously, stream 0x0000..0x0013 (20 words). The output sequence must be identical, in order, with no gaps after the first-word latency.
- Enable gating: with 4 words stored, drop i_enable for 5 cycles while i_in_valid=1 and i_out_ready=1. Required response:
  - o_in_ready=0 and o_out_valid=0 throughout.
  - Count stays 4.
  - On re-enable, the head word appears unchanged.
- Flush and reset mid-stream:
  - With 5 words stored, assert i_flush together with a push and a pop. Next cycle: count=0, o_out_valid=0, and a newly pushed 0xBEEF is the next output.
  - Repeat the scenario using i_reset_n=0 in place of i_flush; the same results are required.
- Randomised backpressure, 1000 cycles, against a reference queue model. Required: no loss, no duplication, order preserved, and o_count always equals the model depth.

Source files
------------

// File: rtl/stream_fifo_buffer.sv
// Valid/ready stream FIFO with first-word-fall-through output, enable gate,
// synchronous flush, occupancy count and almost-full flag.
module stream_fifo_buffer #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 8,
  parameter int ALMOST_FULL = 6
) (
  input  logic                       i_clock,
  input  logic                       i_reset_n,
  input  logic [WIDTH-1:0]           i_in_data,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  output logic [WIDTH-1:0]           o_out_data,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  input  logic                       i_enable,
  input  logic                       i_flush,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_almost_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  // Ready looks only at registered occupancy, so a full FIFO refuses a word
  // even in a cycle where the consumer pops.
  assign o_in_ready    = i_enable && (count_q < DEPTH_C);
  assign o_out_valid   = i_enable && (count_q != '0);
  assign o_out_data    = mem_q[rd_ptr_q];
  assign o_count       = count_q;
  assign o_almost_full = (count_q >= AF_C);

  assign push = i_in_valid && o_in_ready;
  assign pop  = o_out_valid && i_out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; a word pushed alongside flush or reset is dropped.
  always_ff @(posedge i_clock) begin
    if (push && !i_flush && i_reset_n) mem_q[wr_ptr_q] <= i_in_data;
  end

endmodule

// File: tb/tb_stream_fifo_buffer.sv
// Self-checking bench for stream_fifo_buffer against a queue reference model.
module tb_stream_fifo_buffer;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AF    = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             enable;
  logic             flush;
  logic [3:0]       count;
  logic             almost_full;

  logic [WIDTH-1:0] q[$];
  int passed = 0;
  int total  = 0;

  stream_fifo_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ALMOST_FULL(AF)) dut (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_in_data(in_data), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .o_out_data(out_data), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .i_enable(enable), .i_flush(flush),
    .o_count(count), .o_almost_full(almost_full)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    assert (count <= DEPTH) else $error("FAIL count_bound: count=%0d exceeds %0d", count, DEPTH);
  end

  // Drive one cycle of inputs, advance the model by the handshake rules, and
  // leave the inputs applied so outputs can be checked after the edge.
  task automatic drive(input logic en, input logic iv, input logic [WIDTH-1:0] d,
                       input logic ordy, input logic fl, input logic rn);
    bit acc, pp;
    enable = en; in_valid = iv; in_data = d; out_ready = ordy; flush = fl; rst_n = rn;
    acc = iv && en && (q.size() < DEPTH);
    pp  = ordy && en && (q.size() > 0);
    @(posedge clk);
    if (!rn || fl) q.delete();
    else begin
      if (pp)  void'(q.pop_front());
      if (acc) q.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, '0, 0, 0, 0);
    drive(1, 0, '0, 0, 0, 0);
    total++; if (count !== 4'd0) $display("FAIL reset_count: got %0d want 0", count); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_ready_en: got %b want 1", in_ready); else passed++;
    total++; if (almost_full !== 1'b0) $display("FAIL reset_af: got %b want 0", almost_full); else passed++;
    drive(0, 0, '0, 0, 0, 0);
    total++; if (in_ready !== 1'b0) $display("FAIL reset_ready_dis: got %b want 0", in_ready); else passed++;
    drive(1, 0, '0, 0, 0, 1);
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1, 1, WIDTH'(i), 0, 0, 1);
      total++; if (count !== 4'(i)) $display("FAIL fill_count: got %0d want %0d", count, i); else passed++;
      total++; if (out_valid !== 1'b1 || out_data !== 16'h0001)
        $display("FAIL fill_head: got v=%b d=%h want v=1 d=0001", out_valid, out_data); else passed++;
      total++; if (almost_full !== (i >= AF)) $display("FAIL fill_af@%0d: got %b want %b", i, almost_full, i >= AF); else passed++;
      total++; if (in_ready !== (i < DEPTH)) $display("FAIL fill_ready@%0d: got %b want %b", i, in_ready, i < DEPTH); else passed++;
    end
    drive(1, 1, 16'h0009, 0, 0, 1);
    total++; if (count !== 4'd8) $display("FAIL ninth_rejected: count got %0d want 8", count); else passed++;
    // Pop while full with a valid word offered: the offered word is refused.
    drive(1, 1, 16'h000A, 1, 0, 1);
    total++; if (count !== 4'd7) $display("FAIL full_pop_count: got %0d want 7", count); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL full_pop_ready: got %b want 1", in_ready); else passed++;
    total++; if (out_data !== 16'h0002) $display("FAIL full_pop_head: got %h want 0002", out_data); else passed++;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, '0, 1, 0, 1);
      if (q.size() > 0) begin
        total++; if (out_data !== q[0]) $display("FAIL drain_data: got %h want %h", out_data, q[0]); else passed++;
      end
    end
    total++; if (count !== 4'd0 || out_valid !== 1'b0)
      $display("FAIL drain_empty: got count=%0d v=%b want 0/0", count, out_valid); else passed++;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, WIDTH'(i), 1, 0, 1);
      total++; if (out_valid !== 1'b1 || out_data !== WIDTH'(i))
        $display("FAIL wrap_%0d: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, WIDTH'(i)); else passed++;
    end
    drive(1, 0, '0, 1, 0, 1);
    total++; if (count !== 4'd0) $display("FAIL wrap_drain: got %0d want 0", count); else passed++;
  endtask

  task automatic test_enable();
    drive(1, 0, '0, 0, 1, 1);
    for (int i = 0; i < 4; i++) drive(1, 1, WIDTH'(16'h0011 + i), 0, 0, 1);
    for (int c = 0; c < 5; c++) begin
      drive(0, 1, 16'h00EE, 1, 0, 1);
      total++; if (in_ready !== 1'b0 || out_valid !== 1'b0)
        $display("FAIL dis_hs: got rdy=%b v=%b want 0/0", in_ready, out_valid); else passed++;
      total++; if (count !== 4'd4) $display("FAIL dis_count: got %0d want 4", count); else passed++;
    end
    drive(1, 0, '0, 0, 0, 1);
    total++; if (out_valid !== 1'b1 || out_data !== 16'h0011)
      $display("FAIL reen_head: got v=%b d=%h want v=1 d=0011", out_valid, out_data); else passed++;
  endtask

  task automatic test_clear(input bit use_reset);
    drive(1, 0, '0, 0, 1, 1);
    for (int i = 0; i < 5; i++) drive(1, 1, WIDTH'(16'h0100 + i), 0, 0, 1);
    drive(1, 1, 16'h0777, 1, !use_reset, !use_reset);
    total++; if (count !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL clear_%0d: got count=%0d v=%b rdy=%b want 0/0/1", use_reset, count, out_valid, in_ready); else passed++;
    drive(1, 1, 16'hBEEF, 0, 0, 1);
    total++; if (out_valid !== 1'b1 || out_data !== 16'hBEEF || count !== 4'd1)
      $display("FAIL clear_next_%0d: got v=%b d=%h c=%0d want 1/beef/1", use_reset, out_valid, out_data, count); else passed++;
    drive(1, 0, '0, 1, 0, 1);
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 1000; c++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0, WIDTH'($urandom),
            $urandom_range(0, 1), $urandom_range(0, 99) == 0, 1);
      total++;
      if (count !== 4'(q.size()) || out_valid !== (enable && q.size() > 0) ||
          in_ready !== (enable && q.size() < DEPTH) || almost_full !== (q.size() >= AF) ||
          (q.size() > 0 && out_data !== q[0])) begin
        if (bad < 10) $display("FAIL rand_%0d: got c=%0d v=%b rdy=%b af=%b d=%h want c=%0d head=%h",
                               c, count, out_valid, in_ready, almost_full, out_data,
                               q.size(), (q.size() > 0) ? q[0] : 16'h0);
        bad++;
      end else passed++;
    end
  endtask

  initial begin
    rst_n = 0; enable = 1; in_valid = 0; in_data = '0; out_ready = 0; flush = 0;
    test_reset();
    test_fill();
    test_wrap();
    test_enable();
    test_clear(0);
    test_clear(1);
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
